// File: rtl/tsm_pkg.sv
// Shared constants and FSM encoding for the masked S-box sequencer.
package tsm_pkg;

    localparam int unsigned NSHARES = 3;
    localparam int unsigned DP_LAT  = 3;
    localparam int unsigned SelW    = 2;

    typedef logic [7:0] share_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StOut
    } state_e;

    function automatic logic [SelW-1:0] last_sel(input int unsigned nshares);
        return SelW'(nshares - 1);
    endfunction

endpackage

// File: rtl/tsm_sbox_seq_if.sv
// Handshake, randomness and datapath signals of the masked S-box sequencer.
interface tsm_sbox_seq_if;
    import tsm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    share_t            in_share0;
    share_t            in_share1;
    share_t            in_share2;
    logic              rnd_valid;
    share_t            rnd;
    logic              rnd_ready;
    share_t            dp_in;
    share_t            dp_rnd;
    logic              dp_issue;
    logic [SelW-1:0]   dp_sel;
    share_t            dp_out;
    logic              out_valid;
    logic              out_ready;
    share_t            out_share0;
    share_t            out_share1;
    share_t            out_share2;

    modport slave (
        input  in_valid, in_share0, in_share1, in_share2, rnd_valid, rnd, dp_out, out_ready,
        output in_ready, rnd_ready, dp_in, dp_rnd, dp_issue, dp_sel, out_valid,
        output out_share0, out_share1, out_share2
    );

    modport master (
        output in_valid, in_share0, in_share1, in_share2, rnd_valid, rnd, dp_out, out_ready,
        input  in_ready, rnd_ready, dp_in, dp_rnd, dp_issue, dp_sel, out_valid,
        input  out_share0, out_share1, out_share2
    );

endinterface

// File: rtl/tsm_tag_pipe.sv
// Tracks {valid, share index} of issued shares alongside the DP_LAT-deep S-box datapath.
module tsm_tag_pipe #(
    parameter int unsigned DP_LAT = tsm_pkg::DP_LAT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid_i,
    input  logic [tsm_pkg::SelW-1:0] push_tag_i,
    output logic                     tail_valid_o,
    output logic [tsm_pkg::SelW-1:0] tail_tag_o,
    output logic                     busy_o
);
    import tsm_pkg::*;

    logic [DP_LAT-1:0] valid_q;
    logic [SelW-1:0]   tag_q [DP_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DP_LAT); i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= push_valid_i;
            tag_q[0]   <= push_tag_i;
            for (int i = 1; i < int'(DP_LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign tail_valid_o = valid_q[DP_LAT-1];
    assign tail_tag_o   = tag_q[DP_LAT-1];
    assign busy_o       = |valid_q;

endmodule

// File: rtl/tsm_sbox_seq.sv
// Feeds the three Boolean shares of a byte through a pipelined masked S-box datapath, one
// share per cycle with fresh randomness, and collects the shared result in domain order.
module tsm_sbox_seq #(
    parameter int unsigned NSHARES = tsm_pkg::NSHARES,
    parameter int unsigned DP_LAT  = tsm_pkg::DP_LAT
) (
    input logic           clk,
    input logic           rst,
    tsm_sbox_seq_if.slave bus
);
    import tsm_pkg::*;

    localparam logic [SelW-1:0] LastSel = last_sel(NSHARES);

    state_e          state_q;
    logic [SelW-1:0] cnt_q;
    share_t          share_q     [NSHARES];
    share_t          out_share_q [NSHARES];

    logic            issue;
    logic            tail_valid;
    logic [SelW-1:0] tail_tag;
    logic            pipe_busy;

    // A share only moves when fresh randomness is present; otherwise the cycle is a bubble.
    assign issue = (state_q == StIssue) && bus.rnd_valid && !rst;

    tsm_tag_pipe #(
        .DP_LAT(DP_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (issue),
        .push_tag_i   (cnt_q),
        .tail_valid_o (tail_valid),
        .tail_tag_o   (tail_tag),
        .busy_o       (pipe_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            share_q     <= '{default: '0};
            out_share_q <= '{default: '0};
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        share_q[0]  <= bus.in_share0;
                        share_q[1]  <= bus.in_share1;
                        share_q[2]  <= bus.in_share2;
                        out_share_q <= '{default: '0};
                        cnt_q       <= '0;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (bus.rnd_valid) begin
                        if (cnt_q == LastSel) begin
                            state_q <= StDrain;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                // Pipe empties the cycle after the last share is captured.
                StDrain: begin
                    if (!pipe_busy) begin
                        state_q <= StOut;
                    end
                end
                StOut: begin
                    if (bus.out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (tail_valid) begin
                out_share_q[tail_tag] <= bus.dp_out;
            end
        end
    end

    assign bus.in_ready   = (state_q == StIdle) && !rst;
    assign bus.rnd_ready  = issue;
    assign bus.dp_issue   = issue;
    assign bus.dp_sel     = issue ? cnt_q : '0;
    assign bus.dp_in      = issue ? share_q[cnt_q] : '0;
    assign bus.dp_rnd     = issue ? bus.rnd : '0;
    assign bus.out_valid  = (state_q == StOut) && !rst;
    assign bus.out_share0 = rst ? '0 : out_share_q[0];
    assign bus.out_share1 = rst ? '0 : out_share_q[1];
    assign bus.out_share2 = rst ? '0 : out_share_q[2];

endmodule
